// File: rtl/pl_rr_share.sv
// pl_rr_share
// Round-robin scheduler sharing one fixed-latency pipelined resource among
// NREQ requesters. At most one request is granted per cycle. The granted data
// is launched into the resource, and the owner's ID travels down a {valid, tag}
// delay line that is matched to the resource latency. Each result is then
// steered back to its owner. A per-requester outstanding counter caps how many
// transactions each requester may have in flight.
//
// Ports
//   clk      in   clock
//   rst      in   synchronous active-high reset
//   req      in   [NREQ]       request per requester, held until granted
//   reqdat   in   [NREQ*SIZE]  request data, requester i on [SIZE*i +: SIZE]
//   gnt      out  [NREQ]       one-hot grant, combinational from req
//   pl_vld   out  1            launch strobe to the resource (registered)
//   pl_idat  out  [SIZE]       launch data to the resource (registered)
//   pl_odat  in   [SIZE]       resource result, valid DELAY cycles after pl_vld
//   rsp_vld  out  [NREQ]       one-hot response strobe (registered)
//   rsp_dat  out  [SIZE]       response data shared by all requesters (registered)
//   idle     out  1            no transaction outstanding (all counters zero)
module pl_rr_share #(
  parameter int NREQ   = 4,
  parameter int SIZE   = 8,
  parameter int DELAY  = 3,
  parameter int IDW    = 2,
  parameter int MAXOUT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*SIZE-1:0] reqdat,
  output logic [NREQ-1:0]      gnt,
  output logic                 pl_vld,
  output logic [SIZE-1:0]      pl_idat,
  input  logic [SIZE-1:0]      pl_odat,
  output logic [NREQ-1:0]      rsp_vld,
  output logic [SIZE-1:0]      rsp_dat,
  output logic                 idle
);

  localparam int CW = 4;

  logic [IDW-1:0]  r_ptr;
  logic [CW-1:0]   r_cnt [NREQ];
  logic            r_pl_vld;
  logic [SIZE-1:0] r_pl_idat;
  logic [IDW-1:0]  r_tag;
  logic [DELAY-1:0] r_tl_vld;
  logic [IDW-1:0]  r_tl_tag [DELAY];
  logic [NREQ-1:0] r_rsp_vld;
  logic [SIZE-1:0] r_rsp_dat;

  logic [NREQ-1:0] w_elig;
  logic [NREQ-1:0] w_gnt;
  logic            w_found;
  logic [IDW-1:0]  w_sel;
  logic [IDW-1:0]  w_idx;
  logic            w_idle;

  // Eligibility: requesting and below the in-flight cap.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_elig[i] = req[i] && (r_cnt[i] < CW'(MAXOUT));
    end
  end

  // Round-robin search: first eligible requester at or after r_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int off = 0; off < NREQ; off++) begin
      w_idx = IDW'((int'(r_ptr) + off) % NREQ);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end else begin
        w_found = w_found;
      end
    end
  end

  // One-hot grant, forced off while in reset.
  always_comb begin
    w_gnt = '0;
    if (w_found && !rst) begin
      w_gnt[w_sel] = 1'b1;
    end else begin
      w_gnt = '0;
    end
  end

  // Pointer advance and launch register; pl_idat holds when nothing launches.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= '0;
      r_pl_vld  <= 1'b0;
      r_pl_idat <= '0;
      r_tag     <= '0;
    end else if (w_found) begin
      r_ptr     <= IDW'((int'(w_sel) + 1) % NREQ);
      r_pl_vld  <= 1'b1;
      r_pl_idat <= reqdat[SIZE*int'(w_sel) +: SIZE];
      r_tag     <= w_sel;
    end else begin
      r_pl_vld  <= 1'b0;
    end
  end

  // Tag delay line: its last stage lines up with the result on pl_odat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tl_vld <= '0;
      for (int s = 0; s < DELAY; s++) begin
        r_tl_tag[s] <= '0;
      end
    end else begin
      r_tl_vld[0] <= r_pl_vld;
      r_tl_tag[0] <= r_tag;
      for (int s = 1; s < DELAY; s++) begin
        r_tl_vld[s] <= r_tl_vld[s-1];
        r_tl_tag[s] <= r_tl_tag[s-1];
      end
    end
  end

  // Response steering; rsp_dat holds between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_vld <= '0;
      r_rsp_dat <= '0;
    end else if (r_tl_vld[DELAY-1]) begin
      r_rsp_vld <= NREQ'(1'b1) << r_tl_tag[DELAY-1];
      r_rsp_dat <= pl_odat;
    end else begin
      r_rsp_vld <= '0;
    end
  end

  // Outstanding counters: a grant and a response in the same cycle cancel.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (w_gnt[i] && !r_rsp_vld[i]) begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end else if (!w_gnt[i] && r_rsp_vld[i]) begin
          r_cnt[i] <= r_cnt[i] - CW'(1);
        end else begin
          r_cnt[i] <= r_cnt[i];
        end
      end
    end
  end

  // Idle when every counter is zero.
  always_comb begin
    w_idle = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      w_idle = w_idle && (r_cnt[i] == CW'(0));
    end
  end

  // A response must always belong to an outstanding transaction.
  for (genvar g = 0; g < NREQ; g++) begin : g_chk
    a_rsp_owned: assert property (@(posedge clk) disable iff (rst)
      r_rsp_vld[g] |-> (r_cnt[g] != 4'd0));
  end

  assign gnt     = w_gnt;
  assign pl_vld  = r_pl_vld;
  assign pl_idat = r_pl_idat;
  assign rsp_vld = r_rsp_vld;
  assign rsp_dat = r_rsp_dat;
  assign idle    = rst | w_idle;

endmodule

// File: tb/tb_pl_rr_share.sv
// Testbench for pl_rr_share: two instances (MAXOUT=2 and MAXOUT=1), each with
// a DELAY-cycle register pipeline as the shared resource. Expected responses
// are queued when a grant is expected and are compared when rsp_vld fires.
module tb_pl_rr_share;
  localparam int NREQ  = 4;
  localparam int SIZE  = 8;
  localparam int DELAY = 3;
  localparam int IDW   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  req0, req1, gnt0, gnt1, rv0, rv1;
  logic [31:0] reqdat0, reqdat1;
  logic        pl_vld0, pl_vld1, idle0, idle1;
  logic [7:0]  pl_idat0, pl_idat1, pl_odat0, pl_odat1, rd0, rd1;
  logic [7:0]  pipe0 [DELAY];
  logic [7:0]  pipe1 [DELAY];
  logic        tog;
  int          cyc = 0;

  typedef struct {
    int         dut;
    int         id;
    logic [7:0] dat;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  int n_checks;
  int n_errors;

  pl_rr_share #(.NREQ(NREQ), .SIZE(SIZE), .DELAY(DELAY), .IDW(IDW), .MAXOUT(2)) u_dut (
    .clk(clk), .rst(rst), .req(req0), .reqdat(reqdat0), .gnt(gnt0),
    .pl_vld(pl_vld0), .pl_idat(pl_idat0), .pl_odat(pl_odat0),
    .rsp_vld(rv0), .rsp_dat(rd0), .idle(idle0));

  pl_rr_share #(.NREQ(NREQ), .SIZE(SIZE), .DELAY(DELAY), .IDW(IDW), .MAXOUT(1)) u_dut1 (
    .clk(clk), .rst(rst), .req(req1), .reqdat(reqdat1), .gnt(gnt1),
    .pl_vld(pl_vld1), .pl_idat(pl_idat1), .pl_odat(pl_odat1),
    .rsp_vld(rv1), .rsp_dat(rd1), .idle(idle1));

  // Resource model: DELAY-cycle register pipeline; tog scrambles the output.
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    pipe0[0] <= pl_idat0;
    pipe1[0] <= pl_idat1;
    for (int k = 1; k < DELAY; k++) begin
      pipe0[k] <= pipe0[k-1];
      pipe1[k] <= pipe1[k-1];
    end
  end
  assign pl_odat0 = pipe0[DELAY-1] ^ (tog ? cyc[7:0] : 8'h00);
  assign pl_odat1 = pipe1[DELAY-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  // Check the expected one-hot grant and queue the response it must produce.
  task automatic expect_gnt(input int d, input int id, input string tag);
    logic [3:0]  g;
    logic [31:0] rd;
    exp_t        e;
    g  = (d == 1) ? gnt1 : gnt0;
    rd = (d == 1) ? reqdat1 : reqdat0;
    chk(tag, 64'(g), 64'(1) << id);
    e.dut = d;
    e.id  = id;
    e.dat = rd[8*id +: 8];
    e.cyc = cyc + DELAY + 2;
    sb.push_back(e);
  endtask

  task automatic mon_dut(input int d, input logic [3:0] rv, input logic [7:0] rdat);
    exp_t e;
    if (rv !== 4'd0) begin
      if (sb.size() == 0) begin
        chk($sformatf("rsp_unexpected_dut%0d", d), 64'(rv), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_dut", 64'(d), 64'(e.dut));
        chk("rsp_vld", 64'(rv), 64'(1) << e.id);
        chk("rsp_dat", 64'(rdat), 64'(e.dat));
        chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && sb.size() > 0; k++) begin
      step();
    end
    chk("drain_timeout", 64'(sb.size()), 64'd0);
  endtask

  // Response monitor: pops the scoreboard whenever either DUT responds.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        mon_dut(0, rv0, rd0);
        mon_dut(1, rv1, rd1);
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
          e = sb.pop_front();
          chk("rsp_missing_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    tog      = 1'b0;
    req0     = 4'hF;
    req1     = 4'h0;
    reqdat0  = 32'h4433_2211;
    reqdat1  = 32'h0;

    // Reset with every request raised.
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst_gnt", 64'(gnt0), 64'd0);
      chk("rst_pl_vld", 64'(pl_vld0), 64'd0);
      chk("rst_rsp_vld", 64'(rv0), 64'd0);
      chk("rst_idle", 64'(idle0), 64'd1);
    end

    // Release: round robin over all four, first grant to requester 0.
    rst = 1'b0;
    #1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        chk("rr_pl_vld", 64'(pl_vld0), 64'd1);
        chk("rr_pl_idat", 64'(pl_idat0), 64'((reqdat0 >> (8*((k-1)%4))) & 32'hFF));
      end
      expect_gnt(0, k % 4, "rr_gnt");
      step();
    end
    req0 = 4'h0;
    drain();
    step();
    chk("rr_idle", 64'(idle0), 64'd1);

    // Single transfer from requester 2.
    reqdat0[23:16] = 8'hA5;
    req0 = 4'b0100;
    #1;
    expect_gnt(0, 2, "single_gnt");
    step();
    req0 = 4'h0;
    #1;
    chk("single_pl_vld", 64'(pl_vld0), 64'd1);
    chk("single_pl_idat", 64'(pl_idat0), 64'hA5);
    step(); step(); step();
    chk("single_rsp_early", 64'(rv0), 64'd0);
    chk("single_busy", 64'(idle0), 64'd0);
    step();
    chk("single_rsp_vld", 64'(rv0), 64'b0100);
    chk("single_rsp_dat", 64'(rd0), 64'hA5);
    step();
    chk("single_idle", 64'(idle0), 64'd1);
    chk("single_rsp_clr", 64'(rv0), 64'd0);

    // Credit limit with MAXOUT=2 on requester 1.
    reqdat0[15:8] = 8'h5C;
    req0 = 4'b0010;
    #1;
    expect_gnt(0, 1, "credit_gnt0");
    step();
    reqdat0[15:8] = 8'h5D;
    #1;
    expect_gnt(0, 1, "credit_gnt1");
    for (int k = 0; k < 4; k++) begin
      step();
      chk("credit_block", 64'(gnt0), 64'd0);
    end
    step();
    reqdat0[15:8] = 8'h5E;
    #1;
    expect_gnt(0, 1, "credit_gnt2");
    step();
    req0 = 4'h0;
    drain();
    step();
    chk("credit_idle", 64'(idle0), 64'd1);

    // MAXOUT=1 instance: requesters 0 and 3 interleave, then wait on credit.
    reqdat1 = 32'h7300_0070;
    req1 = 4'b1001;
    #1;
    expect_gnt(1, 0, "sim_gnt_a0");
    step();
    expect_gnt(1, 3, "sim_gnt_a3");
    for (int k = 0; k < 4; k++) begin
      step();
      chk("sim_block", 64'(gnt1), 64'd0);
      chk("sim_cnt0_bound", 64'(u_dut1.r_cnt[0] <= 4'd1), 64'd1);
    end
    step();
    expect_gnt(1, 0, "sim_gnt_b0");
    chk("sim_cnt0_bound", 64'(u_dut1.r_cnt[0] <= 4'd1), 64'd1);
    step();
    expect_gnt(1, 3, "sim_gnt_b3");
    chk("sim_cnt0_bound", 64'(u_dut1.r_cnt[0] <= 4'd1), 64'd1);
    step();
    req1 = 4'h0;
    drain();
    step();
    chk("sim_idle", 64'(idle1), 64'd1);

    // Reset mid-flight: three launches (2, wrap to 0, 1), then a reset pulse.
    reqdat0 = 32'h0C0B_0A09;
    req0 = 4'b0111;
    #1;
    chk("mid_gnt2", 64'(gnt0), 64'b0100);
    step();
    chk("mid_gnt0", 64'(gnt0), 64'b0001);
    step();
    chk("mid_gnt1", 64'(gnt0), 64'b0010);
    step();
    req0 = 4'h0;
    rst  = 1'b1;
    tog  = 1'b1;
    sb.delete();
    #1;
    chk("mid_rst_gnt", 64'(gnt0), 64'd0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("mid_no_rsp", 64'(rv0), 64'd0);
    end
    chk("mid_idle", 64'(idle0), 64'd1);
    tog  = 1'b0;
    req0 = 4'hF;
    #1;
    expect_gnt(0, 0, "mid_ptr_reset");
    step();
    req0 = 4'h0;
    drain();
    step();
    chk("end_idle", 64'(idle0), 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
